// File: rtl/tag_sram_ctrl.sv
// Sequencer for a two-bank 64x32 tag SRAM used as a 2-way set-associative tag store.
// Handles lookups and fills with per-set LRU and invalidates the array after reset.
module tag_sram_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned TAG_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_index,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic              rsp_way,
    output logic              init_done,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic              sram_csb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [WORD_W-1:0] sram_i,
    input  logic [WORD_W-1:0] sram_o
);

    localparam int unsigned SETS  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD0, S_RD1, S_CMP, S_WR, S_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              d0_valid_q, d0_valid_d;
    logic [TAG_W-1:0]  d0_tag_q, d0_tag_d;
    logic              victim_q, victim_d;
    logic              hit_q, hit_d;
    logic [SETS-1:0]   lru_q;
    logic              lru_we;
    logic              lru_val;

    logic              ready_d, rsp_valid_d, rsp_hit_d, rsp_way_d, init_done_d;
    logic              web_d, oeb_d, csb_d;
    logic [ADDR_W-1:0] a_d;
    logic [WORD_W-1:0] i_d;

    logic              hit0, hit1, victim_c;
    logic [WORD_W-1:0] fill_word;

    // Way 0 data was captured during RD1; way 1 data is on the bus during CMP.
    assign hit0 = d0_valid_q & (d0_tag_q == tag_q);
    assign hit1 = sram_o[WORD_W-1] & (sram_o[TAG_W-1:0] == tag_q);

    always_comb begin
        fill_word             = '0;
        fill_word[WORD_W-1]   = 1'b1;
        fill_word[TAG_W-1:0]  = tag_q;
    end

    // Victim priority: hit way, invalid way 0, invalid way 1, then LRU way.
    always_comb begin
        victim_c = lru_q[index_q];
        if (hit0)                   victim_c = 1'b0;
        else if (hit1)              victim_c = 1'b1;
        else if (!d0_valid_q)       victim_c = 1'b0;
        else if (!sram_o[WORD_W-1]) victim_c = 1'b1;
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        index_d     = index_q;
        tag_d       = tag_q;
        d0_valid_d  = d0_valid_q;
        d0_tag_d    = d0_tag_q;
        victim_d    = victim_q;
        hit_d       = hit_q;
        lru_we      = 1'b0;
        lru_val     = 1'b0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit;
        rsp_way_d   = rsp_way;
        init_done_d = init_done;
        web_d       = 1'b0;
        oeb_d       = 1'b0;
        csb_d       = 1'b0;
        a_d         = '0;
        i_d         = '0;

        case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_W'(2 * SETS)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    ready_d     = 1'b1;
                end else begin
                    web_d = 1'b1;
                    csb_d = cnt_q[ADDR_W];
                    a_d   = cnt_q[ADDR_W-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    index_d = req_index;
                    tag_d   = req_tag;
                    state_d = S_RD0;
                    oeb_d   = 1'b1;
                    a_d     = req_index;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_RD0: begin
                state_d = S_RD1;
                oeb_d   = 1'b1;
                csb_d   = 1'b1;
                a_d     = index_q;
            end
            S_RD1: begin
                d0_valid_d = sram_o[WORD_W-1];
                d0_tag_d   = sram_o[TAG_W-1:0];
                state_d    = S_CMP;
            end
            S_CMP: begin
                hit_d = hit0 | hit1;
                if (!op_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = hit0 | hit1;
                    rsp_way_d   = hit1 & ~hit0;
                    lru_we      = hit0 | hit1;
                    lru_val     = hit0;
                    state_d     = S_RSP;
                end else begin
                    victim_d = victim_c;
                    web_d    = 1'b1;
                    csb_d    = victim_c;
                    a_d      = index_q;
                    i_d      = fill_word;
                    state_d  = S_WR;
                end
            end
            S_WR: begin
                lru_we      = 1'b1;
                lru_val     = ~victim_q;
                rsp_valid_d = 1'b1;
                rsp_hit_d   = hit_q;
                rsp_way_d   = victim_q;
                state_d     = S_RSP;
            end
            S_RSP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            index_q    <= '0;
            tag_q      <= '0;
            d0_valid_q <= 1'b0;
            d0_tag_q   <= '0;
            victim_q   <= 1'b0;
            hit_q      <= 1'b0;
            lru_q      <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_way    <= 1'b0;
            init_done  <= 1'b0;
            sram_web   <= 1'b0;
            sram_oeb   <= 1'b0;
            sram_csb   <= 1'b0;
            sram_a     <= '0;
            sram_i     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            d0_valid_q <= d0_valid_d;
            d0_tag_q   <= d0_tag_d;
            victim_q   <= victim_d;
            hit_q      <= hit_d;
            if (lru_we) lru_q[index_q] <= lru_val;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_hit    <= rsp_hit_d;
            rsp_way    <= rsp_way_d;
            init_done  <= init_done_d;
            sram_web   <= web_d;
            sram_oeb   <= oeb_d;
            sram_csb   <= csb_d;
            sram_a     <= a_d;
            sram_i     <= i_d;
        end
    end

endmodule
